// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int size_bytes(size_e size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/load_store_unit_byte_mem.sv
// rtl/load_store_unit_byte_mem.sv - byte-wide memory array with per-lane write enables
module byte_mem #(
    parameter int MEM_BYTES = 1024,
    parameter int LANES     = 8,
    parameter int IDX_W     = $clog2(MEM_BYTES)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   addr,
    input  logic [LANES-1:0]   be,
    input  logic [8*LANES-1:0] wdata,
    output logic [8*LANES-1:0] rdata
);

    logic [7:0] mem [MEM_BYTES];

    // Lane i maps to byte addr+i; the index wraps, callers mask illegal spans.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr + IDX_W'(i)] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rdata[8*i +: 8] = mem[addr + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit over a latency-modelled byte memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic              lat_signed;
    size_e             lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    int                nbytes;
    logic              misaligned;
    logic              out_of_range;
    logic              unsupported;
    logic              err;
    logic [LANES-1:0]  be;
    logic              mem_we;
    logic              sign_bit;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] load_data;

    // Error checks use the full address; the extra top bit keeps addr+size from overflowing.
    always_comb begin
        nbytes       = size_bytes(lat_size);
        misaligned   = (lat_addr & ADDR_W'(nbytes - 1)) != '0;
        out_of_range = ({1'b0, lat_addr} + (ADDR_W+1)'(nbytes)) > (ADDR_W+1)'(MEM_BYTES);
        unsupported  = (8 * nbytes) > DATA_W;
        err          = misaligned | out_of_range | unsupported;
        for (int i = 0; i < LANES; i++) begin
            be[i] = (i < nbytes);
        end
    end

    assign mem_we = (state == WAIT) && (cnt == '0) && lat_write && !err;

    byte_mem #(
        .MEM_BYTES (MEM_BYTES),
        .LANES     (LANES),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (lat_addr[IDX_W-1:0]),
        .be    (be),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == 8 * nbytes - 1) begin
                sign_bit = mem_rdata[i];
            end
        end
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < 8 * nbytes) ? mem_rdata[i] : (lat_signed & sign_bit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_B;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_signed <= req_signed;
                        lat_size   <= size_e'(req_size);
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        cnt        <= CNT_W'(LATENCY - 1);
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || lat_write) ? '0 : load_data;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int MEM_BYTES = 1024;
    localparam int LATENCY   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] mm [MEM_BYTES];

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          sg;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: byte array plus the access rules written as plain arithmetic.
    task automatic model_op(input bit w, input logic [1:0] sz, input bit sg, input logic [63:0] a,
                            input logic [63:0] wd, output bit e, output logic [63:0] d);
        int nb;
        logic [64:0] end_a;
        nb    = 1 << sz;
        end_a = {1'b0, a} + 65'(nb);
        e     = (a % 64'(nb) != 0) || (end_a > 65'(MEM_BYTES)) || (8 * nb > DATA_W);
        d     = '0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) d[8*i +: 8] = mm[int'(a) + i];
                if (sg && nb < 8 && d[8*nb-1]) d = d | (~64'd0 << (8 * nb));
            end
        end
    endtask

    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg, input logic [63:0] a,
                          input logic [63:0] wd, input bit hold, output bit e, output logic [63:0] d);
        int k;
        bit got;
        @(negedge clk);
        chk("ready_before_req", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        k   = 0;
        got = 1'b0;
        while (!got && k < 4 * LATENCY + 8) begin
            @(posedge clk);
            #1;
            k++;
            got = resp_valid;
        end
        req_valid = 1'b0;
        chk("resp_latency", 64'(k), 64'(LATENCY));
        chk("busy_in_resp", busy, 1);
        e = resp_err;
        d = resp_rdata;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", resp_valid, 0);
    endtask

    task automatic run_check(input string tag, input bit w, input logic [1:0] sz, input bit sg,
                             input logic [63:0] a, input logic [63:0] wd, input bit hold);
        bit e, me;
        logic [63:0] d, md;
        do_req(w, sz, sg, a, wd, hold, e, d);
        model_op(w, sz, sg, a, wd, me, md);
        chk({tag, "_err"}, e, me);
        chk({tag, "_rdata"}, d, md);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
    endtask

    initial begin
        bit          e, me, seen;
        logic [63:0] d, md, a;
        logic [1:0]  sz;

        vecs.push_back('{1, 2'd3, 0, 64'd0,    64'h200,                 0, 64'h0});
        vecs.push_back('{0, 2'd3, 0, 64'd0,    64'h0,                   0, 64'h200});
        vecs.push_back('{1, 2'd3, 0, 64'd16,   64'h1122334455667788,    0, 64'h0});
        vecs.push_back('{1, 2'd0, 0, 64'd16,   64'hFFFFFFFFFFFFFF80,    0, 64'h0});
        vecs.push_back('{0, 2'd3, 0, 64'd16,   64'h0,                   0, 64'h1122334455667780});
        vecs.push_back('{0, 2'd3, 1, 64'd16,   64'h0,                   0, 64'h1122334455667780});
        vecs.push_back('{0, 2'd0, 0, 64'd16,   64'h0,                   0, 64'h80});
        vecs.push_back('{0, 2'd0, 1, 64'd16,   64'h0,                   0, 64'hFFFFFFFFFFFFFF80});
        vecs.push_back('{1, 2'd1, 0, 64'd2,    64'h123456789ABCBEEF,    0, 64'h0});
        vecs.push_back('{0, 2'd1, 1, 64'd2,    64'h0,                   0, 64'hFFFFFFFFFFFFBEEF});
        vecs.push_back('{0, 2'd1, 0, 64'd2,    64'h0,                   0, 64'hBEEF});
        vecs.push_back('{0, 2'd2, 0, 64'd0,    64'h0,                   0, 64'hBEEF0200});
        vecs.push_back('{0, 2'd2, 1, 64'd0,    64'h0,                   0, 64'hFFFFFFFFBEEF0200});
        vecs.push_back('{0, 2'd1, 0, 64'd3,    64'h0,                   1, 64'h0});
        vecs.push_back('{0, 2'd2, 0, 64'd6,    64'h0,                   1, 64'h0});
        vecs.push_back('{0, 2'd3, 0, 64'd4,    64'h0,                   1, 64'h0});
        vecs.push_back('{1, 2'd2, 0, 64'd6,    64'hFFFFFFFF,            1, 64'h0});
        vecs.push_back('{0, 2'd3, 0, 64'd0,    64'h0,                   0, 64'h00000000BEEF0200});
        vecs.push_back('{1, 2'd3, 0, 64'd1016, 64'hA5A5A5A55A5A5A5A,    0, 64'h0});
        vecs.push_back('{1, 2'd3, 0, 64'd1020, 64'hFFFFFFFFFFFFFFFF,    1, 64'h0});
        vecs.push_back('{0, 2'd3, 0, 64'd1016, 64'h0,                   0, 64'hA5A5A5A55A5A5A5A});
        vecs.push_back('{1, 2'd3, 0, 64'h1_0000_0000, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0});
        vecs.push_back('{0, 2'd3, 0, 64'd0,    64'h0,                   0, 64'h00000000BEEF0200});
        vecs.push_back('{0, 2'd0, 1, 64'd1023, 64'h0,                   0, 64'hFFFFFFFFFFFFFFA5});
        vecs.push_back('{0, 2'd1, 0, 64'd1022, 64'h0,                   0, 64'hA5A5});
        vecs.push_back('{0, 2'd0, 0, 64'd1024, 64'h0,                   1, 64'h0});

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("after_reset");

        for (int i = 0; i < MEM_BYTES / 8; i++) begin
            run_check("fill", 1'b1, 2'd3, 1'b0, 64'(i * 8), {$urandom, $urandom}, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, 1'b0, e, d);
            model_op(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, me, md);
            chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        end

        // req_valid held through WAIT and RESP must still yield a single response.
        run_check("hold", 1'b0, 2'd3, 1'b0, 64'd16, 64'h0, 1'b1);
        seen = 1'b0;
        repeat (LATENCY + 3) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("hold_single_resp", seen, 0);

        // Reset in WAIT of a store: dropped, no response, memory keeps old data.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 64'd8;
        req_wdata  = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_in_wait", busy, 1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (LATENCY + 3) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_reset", seen, 0);
        run_check("load_after_reset", 1'b0, 2'd3, 1'b0, 64'd8, 64'h0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = {$urandom, $urandom};
                1:       a = 64'($urandom_range(0, MEM_BYTES + 8));
                default: a = 64'($urandom_range(0, MEM_BYTES - 1)) & ~((64'd1 << sz) - 64'd1);
            endcase
            run_check("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                      {$urandom, $urandom}, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
